// File: rtl/phy_rx_framer_if.sv
// Bit-stream input and framed-output bundle between the BMC decoder and the receive framer.
// The master drives decoded bits and clear; the slave (framer) returns bytes and frame strobes.
interface phy_rx_framer_if;
    logic       rx_bit;
    logic       rx_bit_en;
    logic       rx_clr;
    logic [7:0] rx_byte;
    logic       rx_byte_en;
    logic       rx_sop_det;
    logic [1:0] rx_sop_type;
    logic       rx_eop;
    logic       rx_err;
    logic       rx_busy;

    modport master (
        output rx_bit, rx_bit_en, rx_clr,
        input  rx_byte, rx_byte_en, rx_sop_det, rx_sop_type, rx_eop, rx_err, rx_busy
    );

    modport slave (
        input  rx_bit, rx_bit_en, rx_clr,
        output rx_byte, rx_byte_en, rx_sop_det, rx_sop_type, rx_eop, rx_err, rx_busy
    );
endinterface

// File: rtl/phy_rx_framer.sv
// Receive framer: preamble lock, ordered-set hunt, 4b5b symbol decode into bytes.
// Latency: every strobe is registered, one cycle after the rx_bit_en carrying the completing bit.
// No backpressure: bits are consumed as strobed; rx_clr drops the coincident bit.
module phy_rx_framer #(
    parameter int PREAMBLE_MIN = 16,
    parameter int HUNT_MAX     = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    phy_rx_framer_if.slave rx
);
    localparam int AW = $clog2(PREAMBLE_MIN + 1);
    localparam int HW = $clog2(HUNT_MAX + 1);
    localparam logic [AW-1:0] ALT_SAT  = AW'(PREAMBLE_MIN);
    localparam logic [HW-1:0] HUNT_LIM = HW'(HUNT_MAX);

    localparam logic [4:0] K_S1  = 5'b11000;
    localparam logic [4:0] K_S2  = 5'b10001;
    localparam logic [4:0] K_S3  = 5'b00110;
    localparam logic [4:0] K_R1  = 5'b00111;
    localparam logic [4:0] K_R2  = 5'b11001;
    localparam logic [4:0] K_EOP = 5'b01101;

    // Oldest symbol sits in the low bits of the window.
    localparam logic [19:0] OS_SOP  = {K_S2, K_S1, K_S1, K_S1};
    localparam logic [19:0] OS_SOP1 = {K_S3, K_S3, K_S1, K_S1};
    localparam logic [19:0] OS_SOP2 = {K_S3, K_S1, K_S3, K_S1};
    localparam logic [19:0] OS_HRST = {K_R2, K_R1, K_R1, K_R1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] alt_q, alt_d, alt_next;
    logic [HW-1:0] hunt_q, hunt_d, hunt_next;
    logic          hunting_q, hunting_d;
    logic [18:0]   hist_q, hist_d;
    logic          prev_q, prev_d;
    logic [2:0]    bit_q, bit_d;
    logic          nib_hi_q, nib_hi_d;
    logic [3:0]    low_q, low_d;
    logic [7:0]    byte_q, byte_d;
    logic [1:0]    type_q, type_d;
    logic          byte_en_q, byte_en_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          err_q, err_d;
    logic          go_idle;
    logic [19:0]   win;
    logic [4:0]    sym;
    logic [4:0]    dec;

    // Returns {valid, nibble}; valid=0 for K-codes and illegal codes.
    function automatic logic [4:0] decode_sym(input logic [4:0] s);
        logic [4:0] r;
        r = 5'b0;
        case (s)
            5'b11110: r = {1'b1, 4'h0};
            5'b01001: r = {1'b1, 4'h1};
            5'b10100: r = {1'b1, 4'h2};
            5'b10101: r = {1'b1, 4'h3};
            5'b01010: r = {1'b1, 4'h4};
            5'b01011: r = {1'b1, 4'h5};
            5'b01110: r = {1'b1, 4'h6};
            5'b01111: r = {1'b1, 4'h7};
            5'b10010: r = {1'b1, 4'h8};
            5'b10011: r = {1'b1, 4'h9};
            5'b10110: r = {1'b1, 4'hA};
            5'b10111: r = {1'b1, 4'hB};
            5'b11010: r = {1'b1, 4'hC};
            5'b11011: r = {1'b1, 4'hD};
            5'b11100: r = {1'b1, 4'hE};
            5'b11101: r = {1'b1, 4'hF};
            default:  r = 5'b0;
        endcase
        return r;
    endfunction

    // The 20-bit match window is the 19 bits of history plus the incoming bit.
    assign win = {rx.rx_bit, hist_q};
    assign sym = win[19:15];
    assign dec = decode_sym(sym);

    always_comb begin
        state_d   = state_q;
        alt_d     = alt_q;
        hunt_d    = hunt_q;
        hunting_d = hunting_q;
        hist_d    = hist_q;
        prev_d    = prev_q;
        bit_d     = bit_q;
        nib_hi_d  = nib_hi_q;
        low_d     = low_q;
        byte_d    = byte_q;
        type_d    = type_q;
        byte_en_d = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        err_d     = 1'b0;
        go_idle   = 1'b0;
        alt_next  = alt_q;
        hunt_next = hunt_q;

        if (rx.rx_clr) begin
            state_d   = IDLE;
            alt_d     = '0;
            hunt_d    = '0;
            hunting_d = 1'b0;
            hist_d    = '0;
            prev_d    = 1'b1;
            bit_d     = '0;
            nib_hi_d  = 1'b0;
            low_d     = '0;
            byte_d    = '0;
            type_d    = '0;
        end else if (rx.rx_bit_en) begin
            hist_d = win[19:1];
            prev_d = rx.rx_bit;
            if (rx.rx_bit != prev_q)
                alt_next = (alt_q == ALT_SAT) ? alt_q : alt_q + AW'(1);
            else
                alt_next = AW'(1);

            case (state_q)
                IDLE: begin
                    alt_d = alt_next;
                    if (alt_next == ALT_SAT) begin
                        state_d   = HUNT;
                        hunt_d    = '0;
                        hunting_d = 1'b0;
                    end
                end
                HUNT: begin
                    // The abort budget only starts once the preamble breaks.
                    if (hunting_q) begin
                        hunt_next = hunt_q + HW'(1);
                    end else if (rx.rx_bit == prev_q) begin
                        hunting_d = 1'b1;
                        hunt_next = HW'(1);
                    end
                    hunt_d = hunt_next;
                    if (win == OS_SOP || win == OS_SOP1 || win == OS_SOP2) begin
                        sop_d    = 1'b1;
                        type_d   = (win == OS_SOP) ? 2'd0 : (win == OS_SOP1) ? 2'd1 : 2'd2;
                        state_d  = DATA;
                        bit_d    = '0;
                        nib_hi_d = 1'b0;
                    end else if (win == OS_HRST) begin
                        sop_d   = 1'b1;
                        type_d  = 2'd3;
                        go_idle = 1'b1;
                    end else if (hunt_next == HUNT_LIM) begin
                        err_d   = 1'b1;
                        go_idle = 1'b1;
                    end
                end
                DATA: begin
                    if (bit_q == 3'd4) begin
                        bit_d = '0;
                        if (dec[4]) begin
                            if (nib_hi_q) begin
                                byte_d    = {dec[3:0], low_q};
                                byte_en_d = 1'b1;
                                nib_hi_d  = 1'b0;
                            end else begin
                                low_d    = dec[3:0];
                                nib_hi_d = 1'b1;
                            end
                        end else if (sym == K_EOP) begin
                            eop_d   = ~nib_hi_q;
                            err_d   = nib_hi_q;
                            go_idle = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            go_idle = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                default: go_idle = 1'b1;
            endcase

            if (go_idle) begin
                state_d   = IDLE;
                alt_d     = '0;
                hunt_d    = '0;
                hunting_d = 1'b0;
                bit_d     = '0;
                nib_hi_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alt_q     <= '0;
            hunt_q    <= '0;
            hunting_q <= 1'b0;
            hist_q    <= '0;
            prev_q    <= 1'b1;
            bit_q     <= '0;
            nib_hi_q  <= 1'b0;
            low_q     <= '0;
            byte_q    <= '0;
            type_q    <= '0;
            byte_en_q <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alt_q     <= alt_d;
            hunt_q    <= hunt_d;
            hunting_q <= hunting_d;
            hist_q    <= hist_d;
            prev_q    <= prev_d;
            bit_q     <= bit_d;
            nib_hi_q  <= nib_hi_d;
            low_q     <= low_d;
            byte_q    <= byte_d;
            type_q    <= type_d;
            byte_en_q <= byte_en_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
        end
    end

    assign rx.rx_byte     = byte_q;
    assign rx.rx_byte_en  = byte_en_q;
    assign rx.rx_sop_det  = sop_q;
    assign rx.rx_sop_type = type_q;
    assign rx.rx_eop      = eop_q;
    assign rx.rx_err      = err_q;
    assign rx.rx_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_phy_rx_framer.sv
// Directed frames into phy_rx_framer; expected strobes are queued with their cycle and checked by a monitor.
`timescale 1ns/1ps
module tb_phy_rx_framer;
    localparam logic [4:0] K_S1  = 5'b11000;
    localparam logic [4:0] K_S2  = 5'b10001;
    localparam logic [4:0] K_S3  = 5'b00110;
    localparam logic [4:0] K_R1  = 5'b00111;
    localparam logic [4:0] K_R2  = 5'b11001;
    localparam logic [4:0] K_EOP = 5'b01101;
    localparam logic [4:0] D_3   = 5'b10101;
    localparam logic [4:0] D_5   = 5'b01011;
    localparam logic [4:0] D_A   = 5'b10110;
    localparam logic [4:0] D_C   = 5'b11010;

    localparam logic [19:0] OS_SOP  = {K_S2, K_S1, K_S1, K_S1};
    localparam logic [19:0] OS_SOP1 = {K_S3, K_S3, K_S1, K_S1};
    localparam logic [19:0] OS_SOP2 = {K_S3, K_S1, K_S3, K_S1};
    localparam logic [19:0] OS_HRST = {K_R2, K_R1, K_R1, K_R1};

    localparam logic [1:0] EV_SOP  = 2'd0;
    localparam logic [1:0] EV_BYTE = 2'd1;
    localparam logic [1:0] EV_EOP  = 2'd2;
    localparam logic [1:0] EV_ERR  = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int          n_vec;
    int          n_err;
    exp_t        sb_q[$];

    phy_rx_framer_if bus ();

    phy_rx_framer #(
        .PREAMBLE_MIN(16),
        .HUNT_MAX    (20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            int   nstb;
            logic [1:0] kind;
            logic [7:0] data;
            exp_t e;
            nstb = int'(bus.rx_byte_en) + int'(bus.rx_sop_det) + int'(bus.rx_eop) + int'(bus.rx_err);
            if (nstb != 0) begin
                check("strobe_onehot", nstb, 1);
                kind = bus.rx_sop_det ? EV_SOP : bus.rx_byte_en ? EV_BYTE : bus.rx_eop ? EV_EOP : EV_ERR;
                data = (kind == EV_SOP) ? {6'd0, bus.rx_sop_type} : (kind == EV_BYTE) ? bus.rx_byte : 8'd0;
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe: got kind %0d data %0h at cycle %0d, expected none", kind, data, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("ev_kind", {30'd0, kind}, {30'd0, e.kind});
                    check("ev_data", {24'd0, data}, {24'd0, e.data});
                    check("ev_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input bit e, input logic [1:0] k, input logic [7:0] d);
        @(negedge clk);
        bus.rx_bit    = b;
        bus.rx_bit_en = 1'b1;
        if (e) sb_q.push_back('{k, d, cyc + 1});
        @(negedge clk);
        bus.rx_bit_en = 1'b0;
    endtask

    // Sends n bits LSB first; the expectation, if any, rides on the last bit.
    task automatic send_word(input logic [19:0] w, input int n, input bit e, input logic [1:0] k, input logic [7:0] d);
        for (int i = 0; i < n; i++)
            send_bit(w[i], e && (i == n - 1), k, d);
    endtask

    task automatic send_sym(input logic [4:0] s, input bit e, input logic [1:0] k, input logic [7:0] d);
        send_word({15'd0, s}, 5, e, k, d);
    endtask

    task automatic send_alt(input int n);
        for (int i = 0; i < n; i++)
            send_bit(logic'(i % 2), 1'b0, EV_SOP, 8'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.rx_clr = 1'b1;
        @(negedge clk);
        bus.rx_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.rx_bit    = 1'b0;
        bus.rx_bit_en = 1'b0;
        bus.rx_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.rx_busy}, 0);
        check("rst_byte", {24'd0, bus.rx_byte}, 0);
        check("rst_type", {30'd0, bus.rx_sop_type}, 0);
        check("rst_strobes", {28'd0, bus.rx_byte_en, bus.rx_sop_det, bus.rx_eop, bus.rx_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Long preamble, SOP, byte A5, EOP.
        send_alt(64);
        send_word(OS_SOP, 20, 1'b1, EV_SOP, 8'd0);
        check("busy_after_sop", {31'd0, bus.rx_busy}, 1);
        send_sym(D_5, 1'b0, EV_SOP, 8'd0);
        send_sym(D_A, 1'b1, EV_BYTE, 8'hA5);
        send_sym(K_EOP, 1'b1, EV_EOP, 8'd0);
        check("busy_after_eop", {31'd0, bus.rx_busy}, 0);
        repeat (3) @(negedge clk);
        check("byte_held", {24'd0, bus.rx_byte}, 32'hA5);
        check("type_held", {30'd0, bus.rx_sop_type}, 0);

        // SOP'' then immediate EOP.
        send_alt(32);
        send_word(OS_SOP2, 20, 1'b1, EV_SOP, 8'd2);
        send_sym(K_EOP, 1'b1, EV_EOP, 8'd0);
        check("type_sop2_held", {30'd0, bus.rx_sop_type}, 2);

        // Hard Reset returns straight to IDLE.
        send_alt(32);
        send_word(OS_HRST, 20, 1'b1, EV_SOP, 8'd3);
        check("busy_after_hrst", {31'd0, bus.rx_busy}, 0);

        // Illegal symbol 00000 after SOP.
        send_alt(32);
        send_word(OS_SOP, 20, 1'b1, EV_SOP, 8'd0);
        send_sym(5'b00000, 1'b1, EV_ERR, 8'd0);
        check("busy_after_badsym", {31'd0, bus.rx_busy}, 0);

        // EOP with a pending low nibble.
        send_alt(32);
        send_word(OS_SOP, 20, 1'b1, EV_SOP, 8'd0);
        send_sym(D_5, 1'b0, EV_SOP, 8'd0);
        send_sym(K_EOP, 1'b1, EV_ERR, 8'd0);
        check("busy_after_halfeop", {31'd0, bus.rx_busy}, 0);

        // Short preamble never arms the hunt.
        send_alt(10);
        send_word(OS_SOP, 20, 1'b0, EV_SOP, 8'd0);
        check("busy_short_pre", {31'd0, bus.rx_busy}, 0);
        pulse_clr();
        check("clr_byte", {24'd0, bus.rx_byte}, 0);
        check("clr_type", {30'd0, bus.rx_sop_type}, 0);

        // Hunt timeout: 17 alternating bits end on 0, so every following 0 counts.
        send_alt(17);
        send_word(20'd0, 19, 1'b0, EV_SOP, 8'd0);
        check("busy_before_timeout", {31'd0, bus.rx_busy}, 1);
        send_bit(1'b0, 1'b1, EV_ERR, 8'd0);
        check("busy_after_timeout", {31'd0, bus.rx_busy}, 0);

        // rx_clr on the last bit of a high nibble drops the byte silently.
        send_alt(32);
        send_word(OS_SOP, 20, 1'b1, EV_SOP, 8'd0);
        send_sym(D_5, 1'b0, EV_SOP, 8'd0);
        send_word({15'd0, D_A}, 4, 1'b0, EV_SOP, 8'd0);
        @(negedge clk);
        bus.rx_bit    = D_A[4];
        bus.rx_bit_en = 1'b1;
        bus.rx_clr    = 1'b1;
        @(negedge clk);
        bus.rx_bit_en = 1'b0;
        bus.rx_clr    = 1'b0;
        check("busy_after_clr", {31'd0, bus.rx_busy}, 0);
        check("byte_after_clr", {24'd0, bus.rx_byte}, 0);

        // Next full frame after the clear decodes normally.
        send_alt(32);
        send_word(OS_SOP1, 20, 1'b1, EV_SOP, 8'd1);
        send_sym(D_C, 1'b0, EV_SOP, 8'd0);
        send_sym(D_3, 1'b1, EV_BYTE, 8'h3C);
        send_sym(K_EOP, 1'b1, EV_EOP, 8'd0);
        check("busy_final", {31'd0, bus.rx_busy}, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
